// File: rtl/crossy_robbers_led_fx_pkg.sv
// Shared widths, mode encoding and helpers for the Crossy Robbers LED effects block.
package crossy_robbers_led_fx_pkg;

    localparam int LED_W  = 12;
    localparam int MODE_W = 2;
    localparam int PWM_W  = 4;
    localparam int PAT_W  = LED_W + MODE_W;

    typedef enum logic [MODE_W-1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_DIM    = 2'b11
    } fx_mode_e;

    function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

endpackage

// File: rtl/crossy_robbers_tick_gen.sv
// Effect-tick prescaler: counts 0..DIV-1; tick flags the wrapping cycle unless a restart wins.
module crossy_robbers_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int              CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (restart || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A restart in the wrap cycle swallows the tick so the caller sees a full period.
    assign tick = w_wrap && !restart;

endmodule

// File: rtl/crossy_robbers_led_fx.sv
// LED effects engine: STATIC, BLINK, CHASE and DIM renderings of a 12-bit pattern.
module crossy_robbers_led_fx
    import crossy_robbers_led_fx_pkg::*;
#(
    parameter int TICK_DIV    = 2500000,
    parameter int BLINK_TICKS = 10,
    parameter int DIM_DUTY    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PAT_W-1:0]  pattern_in,
    output logic [LED_W-1:0]  leds,
    output logic              fx_tick
);

    localparam int                BLK_W      = $clog2(BLINK_TICKS + 1);
    localparam logic [BLK_W-1:0]  BLINK_LAST = BLK_W'(BLINK_TICKS - 1);
    localparam int                DUTY_W     = PWM_W + 1;
    localparam logic [DUTY_W-1:0] DUTY_LIM   = DUTY_W'(DIM_DUTY);

    logic [PAT_W-1:0] r_pattern;
    logic [LED_W-1:0] r_rot;
    logic [BLK_W-1:0] r_blinkCnt;
    logic             r_phase;
    logic [PWM_W-1:0] r_pwmCnt;
    logic [LED_W-1:0] r_leds;
    logic             r_fxTick;

    logic             w_change;
    logic             w_tick;
    fx_mode_e         w_mode;
    logic [LED_W-1:0] w_pat;
    logic [LED_W-1:0] w_rotNext;
    logic [BLK_W-1:0] w_blinkNext;
    logic             w_phaseNext;
    logic [PWM_W-1:0] w_pwmNext;
    logic [LED_W-1:0] w_ledsNext;

    assign w_change = (pattern_in != r_pattern);
    assign w_mode   = fx_mode_e'(pattern_in[PAT_W-1:LED_W]);
    assign w_pat    = pattern_in[LED_W-1:0];

    crossy_robbers_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (w_change),
        .tick    (w_tick)
    );

    // Next-state is computed first so leds reflects the state entering this cycle, not the last one.
    always_comb begin
        w_rotNext   = r_rot;
        w_blinkNext = r_blinkCnt;
        w_phaseNext = r_phase;
        w_pwmNext   = r_pwmCnt + 1'b1;
        if (w_change) begin
            w_rotNext   = w_pat;
            w_blinkNext = '0;
            w_phaseNext = 1'b1;
            w_pwmNext   = '0;
        end else if (w_tick) begin
            w_rotNext = rotl1(r_rot);
            if (r_blinkCnt == BLINK_LAST) begin
                w_blinkNext = '0;
                w_phaseNext = !r_phase;
            end else begin
                w_blinkNext = r_blinkCnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_ledsNext = '0;
        case (w_mode)
            MODE_STATIC: w_ledsNext = w_pat;
            MODE_BLINK:  w_ledsNext = w_pat & {LED_W{w_phaseNext}};
            MODE_CHASE:  w_ledsNext = w_rotNext;
            MODE_DIM:    w_ledsNext = ({1'b0, w_pwmNext} < DUTY_LIM) ? w_pat : '0;
            default:     w_ledsNext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pattern  <= '0;
            r_rot      <= '0;
            r_blinkCnt <= '0;
            r_phase    <= 1'b1;
            r_pwmCnt   <= '0;
            r_leds     <= '0;
            r_fxTick   <= 1'b0;
        end else begin
            r_pattern  <= pattern_in;
            r_rot      <= w_rotNext;
            r_blinkCnt <= w_blinkNext;
            r_phase    <= w_phaseNext;
            r_pwmCnt   <= w_pwmNext;
            r_leds     <= w_ledsNext;
            r_fxTick   <= w_tick;
        end
    end

    assign leds    = r_leds;
    assign fx_tick = r_fxTick;

endmodule

// File: tb/tb_crossy_robbers_led_fx.sv
// Directed bench for crossy_robbers_led_fx at TICK_DIV=4, BLINK_TICKS=2; a second instance uses DIM_DUTY=0.
module tb_crossy_robbers_led_fx;

    typedef struct {
        logic        rstN;
        logic [13:0] pat;
        logic [11:0] expLeds;
        logic        expTick;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [13:0] pattern_in;
    logic [11:0] leds;
    logic        fx_tick;
    logic [11:0] ledsDim0;
    logic        fxTickDim0;

    int   compCount = 0;
    int   failCount = 0;
    vec_t vecs[$];

    crossy_robbers_led_fx #(
        .TICK_DIV(4), .BLINK_TICKS(2), .DIM_DUTY(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in),
        .leds(leds), .fx_tick(fx_tick)
    );

    crossy_robbers_led_fx #(
        .TICK_DIV(4), .BLINK_TICKS(2), .DIM_DUTY(0)
    ) dutDim0 (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in),
        .leds(ledsDim0), .fx_tick(fxTickDim0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic [13:0] p, input logic [11:0] l, input logic t);
        vec_t v;
        v.rstN = r; v.pat = p; v.expLeds = l; v.expTick = t;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic [13:0] p);
        reset_n    = r;
        pattern_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        compCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %03h, expected %03h", name, act, exp);
        end
    endtask

    initial begin
        logic [11:0] one;
        logic [11:0] expL;
        logic        expT;
        one        = 12'h001;
        reset_n    = 1'b0;
        pattern_in = 14'h3FFF;

        // Reset, STATIC, BLINK and the mid-chase change that collides with a tick.
        for (int i = 0; i < 3; i++) addVec(1'b0, 14'h3FFF, 12'h000, 1'b0);
        for (int i = 0; i < 4; i++) addVec(1'b1, 14'h00A5, 12'h0A5, 1'b0);
        addVec(1'b1, 14'h00A5, 12'h0A5, 1'b1);
        for (int i = 0; i < 3; i++) addVec(1'b1, 14'h00A5, 12'h0A5, 1'b0);
        addVec(1'b1, 14'h00A5, 12'h0A5, 1'b1);
        for (int i = 0; i < 4; i++) addVec(1'b1, 14'h1FFF, 12'hFFF, 1'b0);
        addVec(1'b1, 14'h1FFF, 12'hFFF, 1'b1);
        for (int i = 0; i < 3; i++) addVec(1'b1, 14'h1FFF, 12'hFFF, 1'b0);
        addVec(1'b1, 14'h1FFF, 12'h000, 1'b1);
        for (int i = 0; i < 3; i++) addVec(1'b1, 14'h1FFF, 12'h000, 1'b0);
        addVec(1'b1, 14'h1FFF, 12'h000, 1'b1);
        for (int i = 0; i < 3; i++) addVec(1'b1, 14'h1FFF, 12'h000, 1'b0);
        addVec(1'b1, 14'h1FFF, 12'hFFF, 1'b1);
        for (int i = 0; i < 4; i++) addVec(1'b1, 14'h2001, 12'h001, 1'b0);
        addVec(1'b1, 14'h2001, 12'h002, 1'b1);
        for (int i = 0; i < 3; i++) addVec(1'b1, 14'h2001, 12'h002, 1'b0);
        addVec(1'b1, 14'h2001, 12'h004, 1'b1);
        for (int i = 0; i < 3; i++) addVec(1'b1, 14'h2001, 12'h004, 1'b0);
        addVec(1'b1, 14'h2001, 12'h008, 1'b1);
        for (int i = 0; i < 3; i++) addVec(1'b1, 14'h2001, 12'h008, 1'b0);
        for (int i = 0; i < 4; i++) addVec(1'b1, 14'h2003, 12'h003, 1'b0);
        addVec(1'b1, 14'h2003, 12'h006, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].pat);
            checkOutput($sformatf("vec%0d leds", i), leds, vecs[i].expLeds);
            checkOutput($sformatf("vec%0d fx_tick", i), {11'd0, fx_tick}, {11'd0, vecs[i].expTick});
            checkOutput($sformatf("vec%0d duty0 leds", i), ledsDim0, vecs[i].expLeds);
        end

        // Full chase rotation: twelve ticks return the lit bit to position 0.
        applyStimulus(1'b1, 14'h2001);
        checkOutput("chase load leds", leds, 12'h001);
        for (int t = 1; t <= 12; t++) begin
            for (int c = 1; c <= 4; c++) begin
                applyStimulus(1'b1, 14'h2001);
                expL = (c == 4) ? (one << (t % 12)) : (one << ((t - 1) % 12));
                expT = (c == 4);
                checkOutput($sformatf("chase t%0d c%0d leds", t, c), leds, expL);
                checkOutput($sformatf("chase t%0d c%0d fx_tick", t, c), {11'd0, fx_tick}, {11'd0, expT});
            end
        end

        // DIM: on for the first 4 of every 16 cycles after the change; duty 0 instance stays dark.
        for (int j = 0; j < 32; j++) begin
            applyStimulus(1'b1, 14'h3FFF);
            expL = ((j % 16) < 4) ? 12'hFFF : 12'h000;
            checkOutput($sformatf("dim c%0d leds", j), leds, expL);
            checkOutput($sformatf("dim0 c%0d leds", j), ledsDim0, 12'h000);
        end

        // Reset overrides a simultaneous change; a zero pattern after release is not a change.
        applyStimulus(1'b0, 14'h2001);
        checkOutput("midreset leds", leds, 12'h000);
        checkOutput("midreset fx_tick", {11'd0, fx_tick}, 12'h000);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b1, 14'h0000);
            checkOutput($sformatf("post-reset c%0d leds", c), leds, 12'h000);
            checkOutput($sformatf("post-reset c%0d fx_tick", c), {11'd0, fx_tick}, {11'd0, (c == 4)});
        end

        // All-ones chase is steady.
        for (int c = 0; c <= 8; c++) begin
            applyStimulus(1'b1, 14'h2FFF);
            checkOutput($sformatf("chase ones c%0d leds", c), leds, 12'hFFF);
            checkOutput($sformatf("chase ones c%0d fx_tick", c), {11'd0, fx_tick},
                        {11'd0, (c == 4) || (c == 8)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule

// File: doc/crossy_robbers_led_fx.md
CROSSY_ROBBERS_LED_FX -- requirements
Module: crossy_robbers_led_fx

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 2500000: clk cycles per effect tick (20 Hz at 50 MHz), legal range >= 2.
REQ-002 The block SHALL have parameter BLINK_TICKS, default 10: ticks per blink half-period, legal range >= 1.
REQ-003 The block SHALL have parameter DIM_DUTY, default 4: on-cycles out of 16 in dim mode, legal range 0..16.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port pattern_in, input, 14 bits: the LED PIO output word; [13:12] = mode, [11:0] = LED pattern.
REQ-007 The block SHALL have port leds, output, 12 bits: board LED drive, registered.
REQ-008 The block SHALL have port fx_tick, output, 1 bit: a one-cycle pulse on each effect tick, registered.

Function
REQ-009 Modes SHALL be 00 STATIC, 01 BLINK, 10 CHASE and 11 DIM.
REQ-010 The prescaler SHALL count 0..TICK_DIV-1 and assert fx_tick for exactly one cycle in the cycle after it wraps.
REQ-011 A change is defined as pattern_in differing from its value registered on the previous edge; the block SHALL detect it on the edge where it differs.
REQ-012 On a change, at the same edge, the block SHALL clear the prescaler, clear the blink counter, set phase = 1, load rot = pattern_in[11:0], and clear the PWM counter.
REQ-013 A change SHALL take priority over a tick occurring in the same cycle: no tick is issued and no rotate occurs.
REQ-014 In STATIC mode, leds SHALL equal the registered pattern; pattern_in appears on leds one edge after it is applied.
REQ-015 In BLINK mode, leds SHALL equal pattern & {12{phase}}; phase SHALL toggle after every BLINK_TICKS ticks, so leds is on for TICK_DIV*BLINK_TICKS cycles and then off for the same.
REQ-016 In CHASE mode, leds SHALL equal rot; on each tick rot SHALL rotate left by 1, with bit 11 wrapping to bit 0. A pattern of zero SHALL give leds = 0 permanently, and a pattern of all ones SHALL give a steady 12'hFFF.
REQ-017 In DIM mode, a 4-bit PWM counter SHALL run freely; leds = pattern when pwm_cnt < DIM_DUTY, else 0. DIM_DUTY = 0 SHALL give always off and DIM_DUTY = 16 SHALL give always on.
REQ-018 The first output after a change SHALL be the "on" state in every mode (phase = 1, pwm_cnt = 0).
REQ-019 The first tick after a change SHALL appear TICK_DIV cycles after the change edge.
REQ-020 Counters SHALL wrap silently. Widths: prescaler $clog2(TICK_DIV), blink counter $clog2(BLINK_TICKS+1), PWM counter 4 bits.

Reset
REQ-021 While reset_n = 0 at a rising clk edge, the block SHALL set leds = 0, fx_tick = 0, prescaler = 0, blink counter = 0, phase = 1, rot = 0, pwm_cnt = 0 and registered pattern = 0.
REQ-022 Reset asserted mid-operation SHALL take effect on the next edge and override any change or tick in that cycle.
REQ-023 After reset release, pattern_in = 0 SHALL produce no change event; any nonzero pattern_in SHALL be treated as a change.

Structure
REQ-024 Package crossy_robbers_led_fx_pkg SHALL hold LED_W = 12, MODE_W = 2, the mode localparams or enum (STATIC, BLINK, CHASE, DIM) and PWM_W = 4.
REQ-025 The prescaler SHALL be a sub-module crossy_robbers_tick_gen (ports clk, reset_n, restart, tick; parameter DIV).
REQ-026 All remaining logic SHALL be in crossy_robbers_led_fx; the block SHALL contain no latches and no asynchronous logic.

Verification (TICK_DIV=4, BLINK_TICKS=2, DIM_DUTY=4)
REQ-027 Reset: hold reset_n = 0 for 3 cycles with pattern_in = 14'h3FFF -> leds = 0 and fx_tick = 0 throughout; after release, leds responds on the next edge.
REQ-028 STATIC: pattern_in = 14'h00A5 -> leds = 12'h0A5 one edge later, with fx_tick pulsing every 4 cycles.
REQ-029 BLINK: pattern_in = 14'h1FFF -> leds = 12'hFFF for 8 cycles, then 12'h000 for 8 cycles, repeating.
REQ-030 CHASE: pattern_in = 14'h2001 -> leds = 12'h001, then 002, 004 ... 800 on each tick, returning to 001 after 12 ticks.
REQ-031 DIM: pattern_in = 14'h3FFF -> leds = 12'hFFF for 4 of every 16 cycles, 0 otherwise; with DIM_DUTY = 0 -> leds = 0 always.
REQ-032 Change mid-chase: at leds = 12'h008, apply 14'h2003 on the same cycle a tick is due -> leds = 12'h003 next edge, no rotate, and the next tick occurs 4 cycles later (leds = 12'h006).
